// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Brief    : Eight-way round-robin arbiter owning the shared 8:1 mux select,
//            with a hold-time limit that forces hand-over under contention.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic       preempt
);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_grant  = 1'b1;
    localparam logic [7:0] c_hold_last = 8'(HOLD_MAX - 1);

    logic [0:0] r_state;
    logic [7:0] r_grant;
    logic [2:0] r_sel;
    logic [2:0] r_ptr;
    logic [7:0] r_hold_cnt;
    logic       r_busy;
    logic       r_preempt;

    logic [7:0] w_others;
    logic [7:0] w_cand;
    logic [2:0] w_idx;
    logic [2:0] w_winner;
    logic       w_found;
    logic       w_release;
    logic       w_timeout;

    // The owner is masked out, so a hand-over can never re-grant it.
    assign w_others  = req & ~r_grant;
    assign w_cand    = (r_state == c_st_idle) ? req : w_others;
    assign w_release = ~req[r_sel];
    assign w_timeout = (r_hold_cnt == c_hold_last);

    // Scan from highest offset down so the lowest offset from r_ptr wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            w_idx = r_ptr + 3'(i);
            if (w_cand[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_grant    <= 8'h00;
            r_sel      <= 3'd0;
            r_ptr      <= 3'd0;
            r_hold_cnt <= 8'd0;
            r_busy     <= 1'b0;
            r_preempt  <= 1'b0;
        end else begin
            r_preempt <= 1'b0;
            if (r_state == c_st_idle) begin
                if (w_found) begin
                    r_state    <= c_st_grant;
                    r_grant    <= 8'h01 << w_winner;
                    r_sel      <= w_winner;
                    r_ptr      <= w_winner + 3'd1;
                    r_hold_cnt <= 8'd0;
                    r_busy     <= 1'b1;
                end
            end else begin
                if ((w_release || w_timeout) && w_found) begin
                    r_grant    <= 8'h01 << w_winner;
                    r_sel      <= w_winner;
                    r_ptr      <= w_winner + 3'd1;
                    r_hold_cnt <= 8'd0;
                    r_preempt  <= ~w_release;
                end else if (w_release) begin
                    r_state <= c_st_idle;
                    r_grant <= 8'h00;
                    r_busy  <= 1'b0;
                end else if (!w_timeout) begin
                    r_hold_cnt <= r_hold_cnt + 8'd1;
                end
            end
        end
    end

    assign grant   = r_grant;
    assign sel     = r_sel;
    assign busy    = r_busy;
    assign preempt = r_preempt;

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one 8:1 bit-mux datapath (the `MUX_8bit` select path) among eight requesters. It grants at most one requester at a time and drives the 3-bit mux select from the current owner. A hold-time limit forces fairness under contention. Grants use a registered one-hot output with back-to-back hand-over. It sits between requesting units and the shared mux/ALU result path.

## Interface
- `HOLD_MAX`, default 16: maximum consecutive granted cycles before the owner is preempted, when others are waiting; legal range 2..255.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  8  level request per requester; held high for as long as the resource is wanted.
- `grant`  out  8  registered one-hot grant; all-zero when idle.
- `sel`  out  3  binary index of the current owner; drives the mux select.
- `busy`  out  1  high while any grant is active (equals OR of `grant`).
- `preempt`  out  1  one-cycle pulse on the cycle the new grant appears after a forced hand-over.

## Operation
- State machine with two states:
  - IDLE: no grant.
  - GRANT: exactly one `grant` bit set; owner index `own`.
- Internal round-robin pointer `ptr` (3 bits). The search order is `ptr`, `ptr+1`, …, `ptr+7`, mod 8. The first requester found wins.
- Internal `hold_cnt`, 8 bits. It is cleared on every new grant and increments each cycle in GRANT. It saturates at `HOLD_MAX-1`.
- IDLE, at a clock edge:
  - If `req != 0`: winner `w` is chosen by search from `ptr`. Set `grant = 1<<w`, `sel = w`, `busy = 1`, `ptr = w+1`, `hold_cnt = 0`. Go to GRANT.
  - Else: stay in IDLE.
- GRANT, at a clock edge, with `others = req & ~grant`:
  - Release: `req[own] == 0`.
    - If `others != 0`, hand over directly to the winner of the search from `ptr`; `preempt = 0`.
    - Else clear `grant`, clear `busy`, and go to IDLE.
  - Timeout: `req[own] == 1`, `hold_cnt == HOLD_MAX-1`, and `others != 0`.
    - Hand over to the winner of the search from `ptr`; `preempt = 1`.
  - Otherwise the owner keeps the grant; `hold_cnt` increments with saturation.
  - Release takes priority over timeout on the same edge.
- Because the owner's own bit is masked out of `others`, the search never re-grants the owner on a hand-over.
- `sel` holds its last value in IDLE so the mux output stays stable.
- Requests that change while their `grant` bit is low have no effect until the next arbitration edge.

## Timing
- Reset values, on the edge where `reset = 1`:
  - `grant = 8'h00`, `sel = 3'd0`, `busy = 0`, `preempt = 0`.
  - `ptr = 0`, `hold_cnt = 0`, state IDLE.
- Reset mid-grant drops the grant on that edge, with no hand-over and no `preempt`.
- `reset` overrides all other inputs.
- Grant latency: a `req` that is high before edge N (in IDLE) produces `grant` after edge N. That is 1 cycle.
- Hand-over: the owner drops `req` before edge N; the new owner's `grant` appears after edge N. There are no dead cycles and no overlapping grants.
- Maximum continuous ownership under contention is exactly `HOLD_MAX` cycles.
- Worst-case wait for a continuously requesting input is `7*HOLD_MAX` cycles.
- `preempt` is high for exactly one cycle and is otherwise 0.
- All outputs are registered. There is no combinational path from `req` to any output.
- Wrap-around: `ptr` after a grant to 7 is 0.

## Test plan
- Reset, then `req = 8'h00` for 5 cycles:
  - During reset: `grant = 00`, `sel = 0`, `busy = 0`, `preempt = 0`.
  - Afterwards: `grant` stays `00` for all 5 cycles.
- Single requester: `req = 8'h20` held for 3 cycles, then dropped.
  - One cycle later: `grant = 20`, `sel = 5`, `busy = 1`.
  - After the drop: `grant = 00` and `busy = 0` one cycle later; `sel` stays 5.
- Round-robin: `req = 8'hFF`, each owner releases after 1 cycle of grant.
  - Grants go `01, 02, 04, …, 80, 01` with no idle cycles; `preempt` stays 0.
- Timeout with `HOLD_MAX = 4`: `req = 8'h81`, neither requester releases.
  - `grant = 01` for 4 cycles, then `80` for 4 cycles, then `01`.
  - `preempt` pulses on the first cycle of each new grant.
- Simultaneous release and timeout with `HOLD_MAX = 4`: owner 2 drops `req` on the edge where `hold_cnt = 3`, with `req[6] = 1`.
  - `grant = 40`, `preempt = 0`.
- Reset mid-grant: with `grant = 08`, pulse `reset` for 1 cycle while `req = 8'h18`.
  - `grant = 00`.
  - Next edge: `grant = 08`, because `ptr` was reset to 0 and requester 3 is the first found.
